// File: rtl/word_uart_tx.sv
// Word-wide UART transmitter: sends a 16-bit word as two serial frames, high byte first.
// Define WORD_UART_TX_PARITY_EN to insert an even-parity bit before each stop bit.
`timescale 1ns / 1ps

module word_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned WORD_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] BaudLast   = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] BaudPenult = CntW'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e          state_q;
    logic [15:0]     word_q;
    logic            byte_idx_q;
    logic [2:0]      bit_cnt_q;
    logic [CntW-1:0] baud_q;
    logic            tx_q;
    logic            ready_q;
    logic            busy_q;
    logic            done_q;

    logic [7:0]      cur_byte;
    logic [2:0]      bit_nxt;
    logic            baud_end;

    always_comb begin
        cur_byte = byte_idx_q ? word_q[7:0] : word_q[15:8];
        bit_nxt  = bit_cnt_q + 3'd1;
        baud_end = (baud_q == BaudLast);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            word_q     <= '0;
            byte_idx_q <= 1'b0;
            bit_cnt_q  <= '0;
            baud_q     <= '0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != StIdle) begin
                baud_q <= baud_end ? '0 : baud_q + 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (in_valid && ready_q) begin
                        word_q     <= in_data[15:0];
                        byte_idx_q <= 1'b0;
                        baud_q     <= '0;
                        tx_q       <= 1'b0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StStart;
                    end
                end
                StStart: begin
                    if (baud_end) begin
                        bit_cnt_q <= '0;
                        tx_q      <= cur_byte[0];
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (baud_end) begin
                        if (bit_cnt_q == 3'd7) begin
`ifdef WORD_UART_TX_PARITY_EN
                            tx_q    <= ^cur_byte;
                            state_q <= StParity;
`else
                            tx_q    <= 1'b1;
                            state_q <= StStop;
`endif
                        end else begin
                            bit_cnt_q <= bit_nxt;
                            tx_q      <= cur_byte[bit_nxt];
                        end
                    end
                end
`ifdef WORD_UART_TX_PARITY_EN
                StParity: begin
                    if (baud_end) begin
                        tx_q    <= 1'b1;
                        state_q <= StStop;
                    end
                end
`endif
                StStop: begin
                    // Registered pulse lands on the final stop-bit cycle of the second byte.
                    if (byte_idx_q && (baud_q == BaudPenult)) begin
                        done_q <= 1'b1;
                    end
                    if (baud_end) begin
                        if (!byte_idx_q) begin
                            byte_idx_q <= 1'b1;
                            tx_q       <= 1'b0;
                            state_q    <= StStart;
                        end else begin
                            byte_idx_q <= 1'b0;
                            ready_q    <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= StIdle;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready = ready_q;
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_word_uart_tx.sv
// Directed bench for word_uart_tx: table of words with hand-computed byte values,
// cycle-exact serial waveform checks, plus back-to-back, ignored-input and reset cases.
`timescale 1ns / 1ps

module tb_word_uart_tx;

    localparam int CPB = 4;
`ifdef WORD_UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int WL = 2 * FB * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        tx;
    logic        busy;
    logic        tx_done;

    int total = 0;
    int bad = 0;

    word_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .WORD_W      (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [15:0] word;
        logic [7:0]  b0;
        logic [7:0]  b1;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected line level for cycle c (1-based from the first start-bit cycle).
    function automatic logic exp_bit(input logic [7:0] b0, input logic [7:0] b1, input int c);
        int         pos;
        int         k;
        logic [7:0] byt;
        pos = (c - 1) / CPB;
        k   = pos % FB;
        byt = (pos < FB) ? b0 : b1;
        if (k == 0) return 1'b0;
        if (k <= 8) return byt[k-1];
        if (FB == 11 && k == 9) return ^byt;
        return 1'b1;
    endfunction

    // Watches one word starting the cycle after acceptance; optionally pokes inputs mid-frame.
    task automatic watch_word(input logic [7:0] b0, input logic [7:0] b1, input int poke);
        for (int c = 1; c <= WL; c++) begin
            @(negedge clk);
            check("tx", tx, exp_bit(b0, b1, c));
            check("tx_done", tx_done, (c == WL));
            check("busy", busy, 1);
            check("in_ready", in_ready, 0);
            if (c == poke) begin
                in_data  = 16'hDEAD;
                in_valid = 1'b1;
            end
            if (c == poke + 1) in_valid = 1'b0;
        end
    endtask

    task automatic check_idle();
        @(negedge clk);
        check("idle in_ready", in_ready, 1);
        check("idle busy", busy, 0);
        check("idle tx_done", tx_done, 0);
        check("idle tx", tx, 1);
    endtask

    task automatic accept(input logic [15:0] w);
        @(negedge clk);
        in_data  = w;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~w;
    endtask

    initial begin
        vecs[0] = '{word: 16'hA53C, b0: 8'hA5, b1: 8'h3C};
        vecs[1] = '{word: 16'h0700, b0: 8'h07, b1: 8'h00};
        vecs[2] = '{word: 16'h8001, b0: 8'h80, b1: 8'h01};
        vecs[3] = '{word: 16'h00FF, b0: 8'h00, b1: 8'hFF};
        vecs[4] = '{word: 16'hFFFF, b0: 8'hFF, b1: 8'hFF};
        vecs[5] = '{word: 16'h5AA5, b0: 8'h5A, b1: 8'hA5};

        // Reset values held for 100 idle cycles.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) check_idle();

        for (int v = 0; v < 6; v++) begin
            accept(vecs[v].word);
            watch_word(vecs[v].b0, vecs[v].b1, -1);
            check_idle();
        end

        // Back-to-back: second word accepted in the first idle cycle.
        @(negedge clk);
        in_data  = 16'h0001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_data = 16'hFFFF;
        watch_word(8'h00, 8'h01, -1);
        check_idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        watch_word(8'hFF, 8'hFF, -1);
        check_idle();

        // Mid-frame input changes and a valid pulse must be ignored.
        accept(16'h1234);
        watch_word(8'h12, 8'h34, 30);
        for (int i = 0; i < 4; i++) check_idle();

        // Asynchronous reset during byte 0 data bits.
        accept(16'hA53C);
        repeat (10) @(negedge clk);
        check("pre-reset tx", tx, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async tx", tx, 1);
        check("async busy", busy, 0);
        check("async in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        check_idle();
        check_idle();
        accept(16'h5555);
        watch_word(8'h55, 8'h55, -1);
        check_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/word_uart_tx.md
Name: word_uart_tx

Overview:
- Serial transmitter that drains a 16-bit word out of the register/memory path onto a single UART-style line, for dumping register and RAM contents to a host.
- Consumes a word through a valid/ready handshake and sends it as two 8N1 frames, high byte first.
- Sits downstream of the 16-bit registers and RAM read ports as the read-out end of the datapath.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit. Legal range is 2 or more. The counter width is $clog2(CLKS_PER_BIT).
- WORD_W, 16: input word width. Fixed at 16 and must not be overridden. It is split into two bytes.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  16  word to transmit; sampled only on acceptance.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept a word.
- tx  output  1  serial line; idles high. Registered output.
- busy  output  1  high from the cycle after acceptance until the frame ends.
- tx_done  output  1  one-cycle pulse when the second stop bit completes.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: tx=1, in_ready=1, busy=0, tx_done=0. State is IDLE; bit counter, byte index and baud counter are all 0.
- Reset mid-frame: tx goes to 1 immediately and asynchronously, and the word in flight is discarded.
- Acceptance: occurs on the posedge where in_valid && in_ready. in_data is captured into a 16-bit holding register.
  - The cycle after acceptance: in_ready=0, busy=1, tx=0 (start bit).
- States: IDLE -> START -> DATA -> STOP -> (START for byte 1 | IDLE).
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits sent LSB first, each held CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
- Byte order: byte 0 = in_data[15:8], byte 1 = in_data[7:0].
  - There is no idle gap between byte 0's stop bit and byte 1's start bit.
- Word length: 20*CLKS_PER_BIT cycles from the first start-bit cycle to the end of the last stop bit.
- End of word: on the last cycle of byte 1's stop bit, tx_done=1 for exactly one cycle.
  - On the following edge: state returns to IDLE, in_ready=1, busy=0.
- Back-to-back words: if in_valid is high in the first IDLE cycle, the word is accepted on that edge. The next start bit begins one cycle later, so at most one idle-high cycle separates words.
- While busy: in_valid is ignored, and in_data changes have no effect.
- Baud counter: counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit position.

Optional Feature:
- Macro: WORD_UART_TX_PARITY_EN.
- When defined: an even-parity bit is inserted after the 8 data bits and before the stop bit. The parity bit is the XOR of the byte's 8 data bits. Each frame is 11 bits, and a word takes 22*CLKS_PER_BIT cycles.
- When undefined: frames are 8N1 (10 bits), a word takes 20*CLKS_PER_BIT cycles, and no parity logic is synthesized.

Test Plan:
- Reset value check: hold rst_n=0, then release. Expect tx=1, in_ready=1, busy=0 and tx_done=0 for 100 cycles with in_valid=0.
- Single word, CLKS_PER_BIT=4: send 16'hA53C with in_valid for one cycle.
  - tx must show 0, then 1,0,1,0,0,1,0,1, then 1 (byte A5), followed immediately by 0, then 0,0,1,1,1,1,0,0, then 1 (byte 3C).
  - Each bit lasts 4 cycles, for 80 cycles total. tx_done pulses once at cycle 80, and in_ready rises at cycle 81.
- Back-to-back: hold in_valid=1 with 16'h0001, then 16'hFFFF.
  - The second word is accepted the cycle in_ready reasserts, and its start bit follows one cycle later.
  - Byte values decode as 00, 01, FF, FF.
- Ignored input while busy: accept 16'h1234, then toggle in_data to 16'hDEAD and pulse in_valid mid-frame. Decoded output is still 12, 34, and only one tx_done pulse occurs.
- Reset mid-frame: assert rst_n=0 during byte 0's data bits. tx goes to 1 immediately, with no waiting for clk. After release, a new 16'h5555 transmits correctly from its start bit.
- Parity build with WORD_UART_TX_PARITY_EN: send 16'h0700. Expect parity bit 1 for byte 07, parity bit 0 for byte 00, tx_done at 88 cycles when CLKS_PER_BIT=4.
